// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Counter width for n slices; a single-slice operation still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// Combinational DIGIT-bit ripple adder; B is inverted when i_m=1 so that
// subtraction is A + ~B + 1 with the +1 supplied through i_cin.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_m,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_bx;

    assign w_c[0] = i_cin;

    // One full adder per bit, carry rippling upward.
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign w_bx[gi]    = i_b[gi] ^ i_m;
        assign o_sum[gi]   = i_a[gi] ^ w_bx[gi] ^ w_c[gi];
        assign w_c[gi + 1] = (i_a[gi] & w_bx[gi]) | (i_a[gi] & w_c[gi]) | (w_bx[gi] & w_c[gi]);
    end

    assign o_cout = w_c[DIGIT];
    assign o_cmsb = w_c[DIGIT - 1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: processes DIGIT bits per cycle, LSB slice first,
// and presents a registered result with carry, overflow and zero flags.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / DIGIT;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_m;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_v;
    logic             r_zero;
    logic             r_ready;
    logic             r_done;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_m    (r_m),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    // New slice enters at the top of the result and shifts down, so after
    // NSLICE steps the first (LSB) slice sits at bit 0.
    if (DIGIT == WIDTH) begin : g_single
        assign w_s_next = w_sum;
    end else begin : g_multi
        assign w_s_next = {w_sum, r_s[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture, slice processing and registered result/status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
            r_zero  <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_state_next == ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_m     <= m;
                        r_carry <= (m == MODE_SUB);
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_s     <= w_s_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_cout;
                        r_v    <= w_cout ^ w_cmsb;
                        r_zero <= (w_s_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign s     = r_s;
    assign cout  = r_cout;
    assign v     = r_v;
    assign zero  = r_zero;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at DIGIT = 4, 1 and 16 (WIDTH = 16).
module tb_serial_add_sub;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic        start_v [3];
    logic        ready_v [3];
    logic        done_v  [3];
    logic [15:0] s_v     [3];
    logic        cout_v  [3];
    logic        v_v     [3];
    logic        zero_v  [3];

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut_d4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .m(m),
        .ready(ready_v[0]), .done(done_v[0]), .s(s_v[0]),
        .cout(cout_v[0]), .v(v_v[0]), .zero(zero_v[0])
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .m(m),
        .ready(ready_v[1]), .done(done_v[1]), .s(s_v[1]),
        .cout(cout_v[1]), .v(v_v[1]), .zero(zero_v[1])
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .m(m),
        .ready(ready_v[2]), .done(done_v[2]), .s(s_v[2]),
        .cout(cout_v[2]), .v(v_v[2]), .zero(zero_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int slices_of(input int k);
        case (k)
            0: return 4;
            1: return 16;
            default: return 1;
        endcase
    endfunction

    // One full operation on instance k, with operands scrambled after acceptance.
    task automatic do_op(input int k, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tm, input logic [15:0] es, input logic ec,
                         input logic ev, input logic ez);
        int lat;
        string p;
        p = $sformatf("k%0d_%h_%h_m%0d", k, ta, tb, tm);
        @(negedge clk);
        a = ta; b = tb; m = tm; start_v[k] = 1'b1;
        check({p, "_ready"}, 32'(ready_v[k]), 32'd1);
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        a = ~ta; b = ~tb; m = ~tm;
        lat = 1;
        while (!done_v[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({p, "_latency"}, 32'(lat), 32'(slices_of(k) + 1));
        check({p, "_s"},    32'(s_v[k]),    32'(es));
        check({p, "_cout"}, 32'(cout_v[k]), 32'(ec));
        check({p, "_v"},    32'(v_v[k]),    32'(ev));
        check({p, "_zero"}, 32'(zero_v[k]), 32'(ez));
        @(posedge clk); #1;
        check({p, "_done_pulse"}, 32'(done_v[k]),  32'd0);
        check({p, "_ready_after"}, 32'(ready_v[k]), 32'd1);
        @(posedge clk); #1;
        check({p, "_s_hold"},    32'(s_v[k]),    32'(es));
        check({p, "_zero_hold"}, 32'(zero_v[k]), 32'(ez));
    endtask

    int dcnt;

    initial begin
        rst = 1'b1; a = '0; b = '0; m = 1'b0;
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d_rst_ready", k), 32'(ready_v[k]), 32'd1);
            check($sformatf("k%0d_rst_done", k),  32'(done_v[k]),  32'd0);
            check($sformatf("k%0d_rst_s", k),     32'(s_v[k]),     32'd0);
            check($sformatf("k%0d_rst_cout", k),  32'(cout_v[k]),  32'd0);
            check($sformatf("k%0d_rst_v", k),     32'(v_v[k]),     32'd0);
            check($sformatf("k%0d_rst_zero", k),  32'(zero_v[k]),  32'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors on every digit size.
        for (int k = 0; k < 3; k++) begin
            do_op(k, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
            do_op(k, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
            do_op(k, 16'h0004, 16'h0009, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0);
            do_op(k, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
            do_op(k, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
            do_op(k, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
            do_op(k, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        end

        // Second start during RUN is ignored; done pulses once.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; m = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; m = 1'b1; start_v[0] = 1'b1;
        check("restart_ready_low", 32'(ready_v[0]), 32'd0);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_v[0]) dcnt++;
        end
        check("restart_done_count", 32'(dcnt), 32'd1);
        check("restart_s",    32'(s_v[0]),    32'h2345);
        check("restart_cout", 32'(cout_v[0]), 32'd0);
        check("restart_v",    32'(v_v[0]),    32'd0);

        // Reset in the second RUN cycle, with start held to test priority.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; m = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst_ready", 32'(ready_v[0]), 32'd1);
        check("midrun_rst_s",     32'(s_v[0]),     32'd0);
        check("midrun_rst_zero",  32'(zero_v[0]),  32'd1);
        check("midrun_rst_done",  32'(done_v[0]),  32'd0);
        rst = 1'b0; start_v[0] = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done_v[0]) dcnt++;
        end
        check("midrun_rst_no_done", 32'(dcnt), 32'd0);
        check("midrun_rst_idle",    32'(ready_v[0]), 32'd1);
        do_op(0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
